// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the register file write arbiter
// Ports: none (package).
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } state_t;

  function automatic int depth_of(input int addr_n);
    return 1 << addr_n;
  endfunction

  localparam int DATA_N_DEF = 4;
  localparam int ADDR_N_DEF = 3;
  localparam int REQ_N_DEF  = 3;
  localparam int DEPTH      = depth_of(ADDR_N_DEF);

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester/register-file bus of the write arbiter
// Signals: clr/busy (sweep control), req/req_wa/req_wd/gnt (requester handshake),
//          rf_we/rf_wa/rf_wd (register file write port).
// Modports: master = requester/register-file side, slave = arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_N = 4,
  parameter int ADDR_N = 3,
  parameter int REQ_N  = 3
) ();

  logic                     clr;
  logic                     busy;
  logic [REQ_N-1:0]         req;
  logic [REQ_N*ADDR_N-1:0]  req_wa;
  logic [REQ_N*DATA_N-1:0]  req_wd;
  logic [REQ_N-1:0]         gnt;
  logic                     rf_we;
  logic [ADDR_N-1:0]        rf_wa;
  logic [DATA_N-1:0]        rf_wd;

  modport master (
    output clr, req, req_wa, req_wd,
    input  busy, gnt, rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  clr, req, req_wa, req_wd,
    output busy, gnt, rf_we, rf_wa, rf_wd
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// rtl/regfile_write_arbiter_rr_pick.sv - combinational round-robin winner search
// Ports: req (masked requests), ptr (last winner) -> win (one-hot), idx (winner index),
//        any (some request set).
module rr_pick #(
  parameter int REQ_N = 3,
  parameter int PTR_W = 2
) (
  input  logic [REQ_N-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [REQ_N-1:0] win,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  // Search ptr+1, ptr+2, ... wrapping; the last candidate is ptr itself.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= REQ_N; k++) begin
      if (!any && req[(int'(ptr) + k) % REQ_N]) begin
        any = 1'b1;
        win[(int'(ptr) + k) % REQ_N] = 1'b1;
        idx = PTR_W'((int'(ptr) + k) % REQ_N);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin owner of the register file write port with clear sweep
// Ports: clk, rst (sync, active-high), bus (slave modport: clr/busy, req/req_wa/req_wd/gnt,
//        rf_we/rf_wa/rf_wd). All outputs registered.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_N = DATA_N_DEF,
  parameter int ADDR_N = ADDR_N_DEF,
  parameter int REQ_N  = REQ_N_DEF
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(REQ_N);
  localparam int LAST  = depth_of(ADDR_N) - 1;

  state_t             state;
  logic [ADDR_N-1:0]  cnt;
  logic [PTR_W-1:0]   ptr;
  logic [REQ_N-1:0]   gnt_q;
  logic               we_q;
  logic [ADDR_N-1:0]  wa_q;
  logic [DATA_N-1:0]  wd_q;
  logic               busy_q;

  logic [REQ_N-1:0]   masked;
  logic [REQ_N-1:0]   win;
  logic [PTR_W-1:0]   win_idx;
  logic               win_any;

  // A requester granted this cycle may still show req; masking it blocks a double grant.
  assign masked = bus.req & ~gnt_q;

  rr_pick #(.REQ_N(REQ_N), .PTR_W(PTR_W)) u_pick (
    .req (masked),
    .ptr (ptr),
    .win (win),
    .idx (win_idx),
    .any (win_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR;
      cnt    <= '0;
      ptr    <= PTR_W'(REQ_N - 1);
      gnt_q  <= '0;
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      busy_q <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          we_q  <= 1'b1;
          wa_q  <= cnt;
          wd_q  <= '0;
          gnt_q <= '0;
          cnt   <= cnt + 1'b1;
          // busy is left high here so it covers the cycle presenting the last address.
          if (cnt == ADDR_N'(LAST)) state <= ARB;
        end
        ARB: begin
          busy_q <= 1'b0;
          if (bus.clr) begin
            gnt_q  <= '0;
            we_q   <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CLEAR;
          end else if (win_any) begin
            gnt_q <= win;
            we_q  <= 1'b1;
            wa_q  <= bus.req_wa[int'(win_idx)*ADDR_N +: ADDR_N];
            wd_q  <= bus.req_wd[int'(win_idx)*DATA_N +: DATA_N];
            ptr   <= win_idx;
          end else begin
            gnt_q <= '0;
            we_q  <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.rf_we = we_q;
  assign bus.rf_wa = wa_q;
  assign bus.rf_wd = wd_q;
  assign bus.busy  = busy_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (we/wa/wd) of the team's 2-read/1-write register file (`regesterFile`).
- Shares that port between REQ_N requesters using round-robin arbitration with a req/gnt handshake.
- Runs a clear sweep that zeroes every register after reset or on command.
- Sits between the datapath units that write results and the register file; the read ports are not touched.

Parameters:
- DATA_N, 4, register data width (matches register file dataN)
- ADDR_N, 3, register address width (matches register file addressN); depth = 2**ADDR_N
- REQ_N, 3, number of write requesters (>=2)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- clr  input  1  one-cycle pulse; start a clear sweep
- busy  output  1  high while a clear sweep is in progress
- req  input  REQ_N  per-requester write request, held until granted
- req_wa  input  REQ_N*ADDR_N  packed write addresses, requester i at bits [i*ADDR_N +: ADDR_N]
- req_wd  input  REQ_N*DATA_N  packed write data, requester i at bits [i*DATA_N +: DATA_N]
- gnt  output  REQ_N  one-hot grant, high for one cycle
- rf_we  output  1  to register file `we`
- rf_wa  output  ADDR_N  to register file `wa`
- rf_wd  output  DATA_N  to register file `wd`

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. All outputs are registered.
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, gnt=0, busy=1. Internal state: state=CLEAR, sweep counter=0, rr pointer=REQ_N-1, so requester 0 has first priority.
- States: CLEAR and ARB.
- CLEAR:
  - Each edge registers rf_we=1, rf_wa=cnt, rf_wd=0, gnt=0, then increments cnt.
  - The first edge with rst=0 presents address 0; the sweep presents 2**ADDR_N consecutive writes, addresses 0..2**ADDR_N-1.
  - The edge that presents the last address also moves state to ARB.
  - busy stays 1 through the cycle presenting the last address and is 0 from the next cycle.
  - req is ignored in CLEAR; held requests stay pending.
  - clr during CLEAR is ignored; the sweep is not restarted.
- ARB:
  - Each edge samples req, masked by current gnt, so the requester granted this cycle is excluded.
  - If any masked req is set: winner = first set bit searching from ptr+1 upward, wrapping modulo REQ_N.
  - Register gnt=onehot(winner), rf_we=1, rf_wa/rf_wd = the winner's slice, ptr=winner.
  - If no masked req is set: gnt=0, rf_we=0; rf_wa/rf_wd hold their previous values; ptr is unchanged.
- Latency: req sampled at edge N → gnt and rf_we high in cycle N..N+1 → the register file commits at edge N+1.
- Handshake: a requester must keep req, req_wa and req_wd stable until it sees gnt. It may drop req combinationally in the grant cycle; the mask prevents a double grant.
- Throughput: one write per cycle while two or more requesters are active. A lone continuous requester is granted every other cycle.
- clr in ARB: that edge performs no grant (gnt=0, rf_we=0), sets state=CLEAR, cnt=0, busy=1.
- rst mid-operation, in either state: return to reset values next cycle. A sweep in progress restarts from address 0 after rst falls.
- Exactly one of {sweep write, granted write, idle} occurs per cycle. gnt is always zero or one-hot. rf_we=1 with gnt=0 only in CLEAR.

Decomposition:
- Shared package `regfile_pkg`:
  - state enum {CLEAR, ARB}
  - default DATA_N=4, ADDR_N=3, REQ_N=3 constants
  - DEPTH = 2**ADDR_N
- One sub-module, `rr_pick`: purely combinational. Inputs: masked req and ptr. Output: one-hot winner plus any flag. Instantiated once in regfile_write_arbiter.

Test Plan:
- Reset sweep: rst=1 for 2 cycles then 0, no req → rf_we=1 for 8 consecutive cycles, rf_wa=0..7, rf_wd=0, gnt=0, busy=1 throughout; busy=0 and rf_we=0 from cycle 9. Read ports of the attached register file return 0 at all 8 addresses.
- Single grant: after sweep, req=3'b010, req_wa slice1=5, req_wd slice1=4'hA, dropped on gnt → one cycle with gnt=3'b010, rf_we=1, rf_wa=5, rf_wd=4'hA; rd0 at ra0=5 reads 4'hA afterwards.
- Round-robin: req=3'b111 held continuously, distinct wa/wd per requester → gnt sequence 001,010,100,001,010,100 on consecutive cycles; rf_we stays 1.
- Mask rule: only req[2] held continuously → gnt=100 on alternate cycles only, never two consecutive cycles.
- clr with pending work: req=3'b001 held, clr pulsed in ARB → no grant that cycle; busy=1 and 8 zero writes to addresses 0..7; gnt=001 in the first ARB cycle after the sweep.
- Reset mid-sweep: rst asserted while rf_wa=3 in CLEAR → outputs at reset values next cycle; after release the sweep restarts at address 0 and runs a full 8 writes; the first ARB grant with req=3'b111 goes to requester 0.
